// File: rtl/cpu_oci_trace_capture.sv
`default_nettype none
// ============================================================================
// Module  : cpu_oci_trace_capture
// Purpose : OCI trace FIFO with overflow counting and an end-of-test drain.
//           Optional CPU_OCI_TRACE_TIMESTAMP_EN prefixes entries with a cycle stamp.
// Rev     : 1.0
// ============================================================================
module cpu_oci_trace_capture #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int OVF_W  = 16,
    parameter int TS_W   = 16,
`ifdef CPU_OCI_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = TS_W + CNT_W + DATA_W
`else
    // TS_W is kept in the parameter list so both builds share one interface.
    localparam int ENTRY_W = CNT_W + DATA_W + 0 * TS_W
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  dct_buffer,
    input  logic [CNT_W-1:0]   dct_count,
    input  logic               dct_valid,
    input  logic               test_ending,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [ADDR_W:0]    fill_level,
    output logic [OVF_W-1:0]   overflow_cnt,
    output logic               busy,
    output logic               test_has_ended
);

    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_DRAIN   = 2'd1,
        S_ENDED   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W:0]     r_wr_ptr;
    logic [ADDR_W:0]     r_rd_ptr;
    logic [ADDR_W:0]     w_wr_ptr_nxt;
    logic [ADDR_W:0]     w_rd_ptr_nxt;
    logic [ADDR_W:0]     w_fill_nxt;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [ENTRY_W-1:0]  r_rd_data;
    logic [ENTRY_W-1:0]  w_entry;
    logic [ENTRY_W-1:0]  w_head_nxt;
    logic [OVF_W-1:0]    r_ovf;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;
    logic                w_drop;

`ifdef CPU_OCI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]     r_ts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_entry = {r_ts, dct_count, dct_buffer};
`else
    assign w_entry = {dct_count, dct_buffer};
`endif

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                        (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_pop      = !w_empty && rd_ready;
    assign w_push_req = (r_state == S_CAPTURE) && dct_valid && (dct_count != '0);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_pop};
    assign w_fill_nxt   = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_head_addr  = w_rd_ptr_nxt[ADDR_W-1:0];

    // The registered head must bypass the array when the next head is the word being written now.
    always_comb begin
        w_head_nxt = '0;
        if (w_fill_nxt != '0) begin
            if (w_push && (w_head_addr == r_wr_ptr[ADDR_W-1:0])) begin
                w_head_nxt = w_entry;
            end else begin
                w_head_nxt = r_mem[w_head_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
            r_ovf     <= '0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_rd_data <= w_head_nxt;
            if (w_drop && (r_ovf != '1)) begin
                r_ovf <= r_ovf + OVF_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CAPTURE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        busy           = 1'b1;
        test_has_ended = 1'b0;
        case (r_state)
            S_CAPTURE: begin
                if (test_ending) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = S_ENDED;
                end
            end
            S_ENDED: begin
                busy           = 1'b0;
                test_has_ended = 1'b1;
            end
            default: begin
                w_state_nxt = S_CAPTURE;
            end
        endcase
    end

    assign rd_valid     = !w_empty;
    assign rd_data      = r_rd_data;
    assign fill_level   = r_wr_ptr - r_rd_ptr;
    assign overflow_cnt = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cpu_oci_trace_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_oci_trace_capture
// Purpose : Vector table, directed corner sequences and random traffic vs. a queue model.
// Rev     : 1.0
// ============================================================================
module tb_cpu_oci_trace_capture;

    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int OVF_W  = 4;
    localparam int TS_W   = 16;
    localparam int LOW_W  = CNT_W + DATA_W;
`ifdef CPU_OCI_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = TS_W + LOW_W;
`else
    localparam int ENTRY_W = LOW_W;
`endif
    localparam int OVF_MAX = (1 << OVF_W) - 1;

    logic               clk;
    logic               reset;
    logic [DATA_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]   dct_count;
    logic               dct_valid;
    logic               test_ending;
    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;
    logic [ADDR_W:0]    fill_level;
    logic [OVF_W-1:0]   overflow_cnt;
    logic               busy;
    logic               test_has_ended;

    cpu_oci_trace_capture #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH),
        .ADDR_W(ADDR_W), .OVF_W(OVF_W), .TS_W(TS_W)
    ) dut (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .test_ending(test_ending), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .fill_level(fill_level),
        .overflow_cnt(overflow_cnt), .busy(busy), .test_has_ended(test_has_ended)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a queue of stored entries plus an abstract phase 0=capture 1=drain 2=ended.
    logic [ENTRY_W-1:0] mq[$];
    int                 m_ovf;
    int                 m_phase;
    logic [TS_W-1:0]    m_ts;

    function automatic logic [ENTRY_W-1:0] mk(input logic [CNT_W-1:0] c,
                                              input logic [DATA_W-1:0] d,
                                              input logic [TS_W-1:0] ts);
        logic [ENTRY_W-1:0] e;
`ifdef CPU_OCI_TRACE_TIMESTAMP_EN
        e = {ts, c, d};
`else
        e = {c, d};
        if (ts == '1) e = {c, d};
`endif
        return e;
    endfunction

    task automatic cycle(input logic rs, input logic v, input logic [CNT_W-1:0] c,
                         input logic [DATA_W-1:0] d, input logic te, input logic rr);
        int sz;
        logic [ENTRY_W-1:0] head;
        reset = rs; dct_valid = v; dct_count = c; dct_buffer = d;
        test_ending = te; rd_ready = rr;
        sz = mq.size();
        if (rs) begin
            mq.delete();
            m_ovf = 0; m_phase = 0; m_ts = '0;
        end else begin
            if (sz != 0 && rr) void'(mq.pop_front());
            if (m_phase == 0 && v && c != 0) begin
                if (sz < DEPTH || (sz != 0 && rr)) mq.push_back(mk(c, d, m_ts));
                else if (m_ovf < OVF_MAX) m_ovf++;
            end
            if (m_phase == 0 && te) m_phase = 1;
            else if (m_phase == 1 && sz == 0) m_phase = 2;
            m_ts = m_ts + 1'b1;
        end
        @(posedge clk);
        #1;
        head = (mq.size() != 0) ? mq[0] : '0;
        chk("m_rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
        chk("m_fill", 64'(fill_level), 64'(mq.size()));
        chk("m_rd_data", 64'(rd_data), 64'(head));
        chk("m_ovf", 64'(overflow_cnt), 64'(m_ovf));
        chk("m_busy", 64'(busy), 64'(m_phase != 2));
        chk("m_ended", 64'(test_has_ended), 64'(m_phase == 2));
    endtask

    typedef struct {
        logic              rs, v, te, rr;
        logic [CNT_W-1:0]  c;
        logic [DATA_W-1:0] d;
        logic              e_valid, e_busy, e_ended;
        int                e_fill, e_ovf;
        logic [LOW_W-1:0]  e_data;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mv(input logic rs, v, input int c, d, input logic te, rr,
                                input logic ev, input int ef, input logic [LOW_W-1:0] ed);
        vec_t r;
        r.rs = rs; r.v = v; r.c = CNT_W'(c); r.d = DATA_W'(d); r.te = te; r.rr = rr;
        r.e_valid = ev; r.e_fill = ef; r.e_data = ed;
        r.e_busy = 1'b1; r.e_ended = 1'b0; r.e_ovf = 0;
        return r;
    endfunction

    logic [CNT_W-1:0]  w_c [20];
    logic [DATA_W-1:0] w_d [20];
    logic [LOW_W-1:0]  exp_low;

    initial begin
        reset = 1'b1; dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
        test_ending = 1'b0; rd_ready = 1'b0;
        mq.delete(); m_ovf = 0; m_phase = 0; m_ts = '0;

        vt[0]  = mv(1, 0, 0, 0,     0, 0, 0, 0, '0);
        for (int i = 1; i <= 5; i++) vt[i] = mv(0, 0, 0, 0, 0, 0, 0, 0, '0);
        vt[6]  = mv(0, 1, 1, 1,     0, 0, 1, 1, {4'd1, 30'h1});
        vt[7]  = mv(0, 1, 2, 2,     0, 0, 1, 2, {4'd1, 30'h1});
        vt[8]  = mv(0, 1, 3, 3,     0, 0, 1, 3, {4'd1, 30'h1});
        vt[9]  = mv(0, 0, 0, 0,     0, 1, 1, 2, {4'd2, 30'h2});
        vt[10] = mv(0, 0, 0, 0,     0, 1, 1, 1, {4'd3, 30'h3});
        vt[11] = mv(0, 0, 0, 0,     0, 1, 0, 0, '0);
        vt[12] = mv(0, 1, 0, 'h5,   0, 0, 0, 0, '0);

        for (int i = 0; i < 13; i++) begin
            cycle(vt[i].rs, vt[i].v, vt[i].c, vt[i].d, vt[i].te, vt[i].rr);
            chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vt[i].e_valid));
            chk($sformatf("vec%0d_fill", i), 64'(fill_level), 64'(vt[i].e_fill));
            chk($sformatf("vec%0d_data", i), 64'(rd_data[LOW_W-1:0]), 64'(vt[i].e_data));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
            chk($sformatf("vec%0d_ended", i), 64'(test_has_ended), 64'(vt[i].e_ended));
            chk($sformatf("vec%0d_ovf", i), 64'(overflow_cnt), 64'(vt[i].e_ovf));
        end

        // Overflow: 20 words into 16 entries, then push+pop while full, zero-count, saturation.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            w_c[i] = CNT_W'((i % 15) + 1);
            w_d[i] = DATA_W'(32'h100 + i);
            cycle(0, 1, w_c[i], w_d[i], 0, 0);
        end
        chk("ovf20_fill", 64'(fill_level), 64'd16);
        chk("ovf20_cnt", 64'(overflow_cnt), 64'd4);
        chk("ovf20_head", 64'(rd_data[LOW_W-1:0]), 64'({w_c[0], w_d[0]}));
        cycle(0, 1, 4'd7, 30'hABC, 0, 1);
        chk("fullpp_fill", 64'(fill_level), 64'd16);
        chk("fullpp_ovf", 64'(overflow_cnt), 64'd4);
        cycle(0, 1, 4'd0, 30'h5A5, 0, 0);
        chk("cnt0_fill", 64'(fill_level), 64'd16);
        chk("cnt0_ovf", 64'(overflow_cnt), 64'd4);
        for (int i = 0; i < 15; i++) cycle(0, 1, 4'd9, 30'h77, 0, 0);
        chk("ovf_sat", 64'(overflow_cnt), 64'(OVF_MAX));
        for (int i = 1; i <= 16; i++) begin
            exp_low = (i < 16) ? {w_c[i], w_d[i]} : {4'd7, 30'hABC};
            chk($sformatf("order%0d", i), 64'(rd_data[LOW_W-1:0]), 64'(exp_low));
            cycle(0, 0, 0, 0, 0, 1);
        end
        chk("drained_valid", 64'(rd_valid), 64'd0);

        // End of test: 5th word arrives with test_ending, later words are ignored.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cycle(0, 1, CNT_W'(i), DATA_W'(i * 3), (i == 5), 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 4'd2, 30'h99, 0, 0);
        chk("end_fill5", 64'(fill_level), 64'd5);
        chk("end_busy_drain", 64'(busy), 64'd1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 4'd2, 30'h99, 0, 1);
        chk("end_fill0", 64'(fill_level), 64'd0);
        cycle(0, 1, 4'd2, 30'h99, 0, 0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_ended", 64'(test_has_ended), 64'd1);
        cycle(0, 1, 4'd2, 30'h99, 1, 0);
        chk("ended_hold", 64'(test_has_ended), 64'd1);
        chk("ended_nopush", 64'(fill_level), 64'd0);

        // Reset in the middle of a drain.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) cycle(0, 1, CNT_W'(i), DATA_W'(i), 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("drain_fill7", 64'(fill_level), 64'd7);
        cycle(1, 0, 0, 0, 0, 0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        cycle(0, 1, 4'd4, 30'h44, 0, 0);
        chk("rst_capture", 64'(fill_level), 64'd1);

        // Empty FIFO with test_ending: one cycle in drain, then ended.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("empty_drain_busy", 64'(busy), 64'd1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("empty_ended", 64'(test_has_ended), 64'd1);

`ifdef CPU_OCI_TRACE_TIMESTAMP_EN
        begin
            logic [TS_W-1:0] ts_a;
            cycle(1, 0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0, 0);
            cycle(0, 1, 4'd1, 30'h11, 0, 0);
            cycle(0, 0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0, 0);
            cycle(0, 1, 4'd2, 30'h22, 0, 0);
            ts_a = rd_data[ENTRY_W-1 -: TS_W];
            chk("ts_first", 64'(ts_a), 64'd1);
            cycle(0, 0, 0, 0, 0, 1);
            chk("ts_delta", 64'(rd_data[ENTRY_W-1 -: TS_W] - ts_a), 64'd3);
        end
`endif

        // Random traffic against the queue model.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  CNT_W'($urandom_range(0, 15)),
                  DATA_W'($urandom),
                  ($urandom_range(0, 119) == 0),
                  ($urandom_range(0, 9) < (i % 200 < 100 ? 3 : 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
